// File: rtl/k2red_arb.sv
// Two-requester round-robin front end sharing one K2-RED reducer (q = 3329, k = 13).
// Two-stage pipeline: S1 holds the granted operand, S2 holds the reduced result.
module k2red (
   input  logic [23:0] c,
   output logic [11:0] cred
);
   logic signed [18:0] cl13;
   logic signed [18:0] chs;
   logic signed [18:0] c1;
   logic signed [12:0] c1h;
   logic signed [12:0] c1l13;
   logic signed [12:0] c2;

   // Bring a value in [-q, 2q) into [0, q).
   function automatic logic [11:0] fold_q(input logic signed [12:0] x);
      logic signed [12:0] y;
      y = x;
      if (x < 13'sd0)
         y = x + 13'sd3329;
      else if (x >= 13'sd3329)
         y = x - 13'sd3329;
      return y[11:0];
   endfunction

   // Two K-RED folds give c2 == 169*c (mod q), with c2 in [-12, 3571].
   always_comb begin
      cl13  = signed'({11'd0, c[7:0]}) * 19'sd13;
      chs   = signed'({3'd0, c[23:8]});
      c1    = cl13 - chs;
      c1h   = 13'(c1 >>> 8);
      c1l13 = signed'({5'd0, c1[7:0]}) * 13'sd13;
      c2    = c1l13 - c1h;
      cred  = fold_q(c2);
   end
endmodule

module k2red_arb #(
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_vld,
   input  logic [23:0]     a_c,
   input  logic [TAGW-1:0] a_tag,
   output logic            a_rdy,
   input  logic            b_vld,
   input  logic [23:0]     b_c,
   input  logic [TAGW-1:0] b_tag,
   output logic            b_rdy,
   output logic            o_vld,
   input  logic            o_rdy,
   output logic [11:0]     o_cred,
   output logic            o_src,
   output logic [TAGW-1:0] o_tag
);
   logic            vld_p1;
   logic [23:0]     c_p1;
   logic            src_p1;
   logic [TAGW-1:0] tag_p1;
   logic [11:0]     cred_p1;

   logic            vld_p2;
   logic [11:0]     cred_p2;
   logic            src_p2;
   logic [TAGW-1:0] tag_p2;

   logic            last;
   logic            gnt_a;
   logic            gnt_b;
   logic            s1_en;
   logic            s2_en;

   // last == 1 means B was served most recently, so A wins the next tie.
   always_comb begin
      gnt_a = a_vld & (~b_vld | last);
      gnt_b = b_vld & (~a_vld | ~last);
      s2_en = ~vld_p2 | o_rdy;
      s1_en = ~vld_p1 | s2_en;
      a_rdy = s1_en & gnt_a & ~rst;
      b_rdy = s1_en & gnt_b & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         last   <= 1'b1;
      end else begin
         if (s1_en)
            vld_p1 <= gnt_a | gnt_b;
         if (s2_en)
            vld_p2 <= vld_p1;
         if (a_rdy)
            last <= 1'b0;
         else if (b_rdy)
            last <= 1'b1;
      end
   end

   // S1: granted operand
   always_ff @(posedge clk) begin
      if (s1_en) begin
         c_p1   <= gnt_b ? b_c : a_c;
         src_p1 <= gnt_b;
         tag_p1 <= gnt_b ? b_tag : a_tag;
      end
   end

   k2red u_k2red (
      .c    (c_p1),
      .cred (cred_p1)
   );

   // S2: reduced result
   always_ff @(posedge clk) begin
      if (s2_en) begin
         cred_p2 <= cred_p1;
         src_p2  <= src_p1;
         tag_p2  <= tag_p1;
      end
   end

   assign o_vld  = vld_p2;
   assign o_cred = cred_p2;
   assign o_src  = src_p2;
   assign o_tag  = tag_p2;
endmodule

// File: tb/tb_k2red_arb.sv
// Directed bench for k2red_arb: grant order, latency, stall, reset flush, plus an
// in-order scoreboard checked against a golden k2red and the 169*c mod 3329 identity.
module tb_k2red_arb;
   logic        clk;
   logic        rst;
   logic        a_vld, b_vld, o_rdy;
   logic [23:0] a_c, b_c;
   logic [3:0]  a_tag, b_tag;
   logic        a_rdy, b_rdy, o_vld, o_src;
   logic [11:0] o_cred;
   logic [3:0]  o_tag;
   logic [23:0] gold_c;
   logic [11:0] gold_cred;

   typedef struct {
      logic [23:0] c;
      logic        src;
      logic [3:0]  tag;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad = 0;

   logic [23:0] bb_c[6]   = '{24'd1, 24'd3330, 24'd99999, 24'd65536, 24'd600000, 24'd0};
   logic [11:0] bb_exp[6] = '{12'd169, 12'd169, 12'd1827, 12'd1, 12'd1989, 12'd0};

   k2red_arb #(.TAGW(4)) dut (
      .clk(clk), .rst(rst),
      .a_vld(a_vld), .a_c(a_c), .a_tag(a_tag), .a_rdy(a_rdy),
      .b_vld(b_vld), .b_c(b_c), .b_tag(b_tag), .b_rdy(b_rdy),
      .o_vld(o_vld), .o_rdy(o_rdy), .o_cred(o_cred), .o_src(o_src), .o_tag(o_tag)
   );

   k2red u_gold (.c(gold_c), .cred(gold_cred));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sb();
      ent_t e;
      if (o_vld === 1'b1) begin
         if (q.size() == 0) begin
            chk("sb_orphan_o_vld", 32'(o_vld), 32'd0);
         end else begin
            e = q[0];
            chk("sb_cred_golden", 32'(o_cred), 32'(gold_cred));
            chk("sb_cred_model", 32'(o_cred), 32'((64'(e.c) * 64'd169) % 64'd3329));
            chk("sb_src", 32'(o_src), 32'(e.src));
            chk("sb_tag", 32'(o_tag), 32'(e.tag));
            if (o_rdy)
               void'(q.pop_front());
         end
      end
      if (rst) begin
         q.delete();
      end else begin
         if (a_vld && a_rdy) q.push_back('{c: a_c, src: 1'b0, tag: a_tag});
         if (b_vld && b_rdy) q.push_back('{c: b_c, src: 1'b1, tag: b_tag});
      end
      gold_c = (q.size() > 0) ? q[0].c : 24'd0;
   endtask

   task automatic half();
      @(negedge clk);
      sb();
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      half();
      edge_();
   endtask

   initial begin
      int idx;
      int acc_stall;
      logic [11:0] hold_cred;
      logic [3:0]  hold_tag;

      rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
      a_c = '0; b_c = '0; a_tag = '0; b_tag = '0; gold_c = '0;

      // reset: no ready while rst is high, no output afterwards
      half();
      chk("rst_a_rdy", 32'(a_rdy), 32'd0);
      chk("rst_b_rdy", 32'(b_rdy), 32'd0);
      edge_();
      cyc();
      rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
      half();
      chk("rst_o_vld", 32'(o_vld), 32'd0);
      edge_();

      // single request, two-cycle latency
      a_vld = 1'b1; a_c = 24'd3330; a_tag = 4'd5;
      half();
      chk("single_a_rdy", 32'(a_rdy), 32'd1);
      edge_();
      a_vld = 1'b0;
      half();
      chk("single_n1_o_vld", 32'(o_vld), 32'd0);
      edge_();
      half();
      chk("single_n2_o_vld", 32'(o_vld), 32'd1);
      chk("single_src", 32'(o_src), 32'd0);
      chk("single_tag", 32'(o_tag), 32'd5);
      chk("single_cred", 32'(o_cred), 32'd169);
      edge_();
      half();
      chk("single_n3_o_vld", 32'(o_vld), 32'd0);
      edge_();

      // contention after reset alternates A,B,A,B
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      a_vld = 1'b1; b_vld = 1'b1; a_tag = 4'd1; b_tag = 4'd2;
      a_c = 24'd1000; b_c = 24'd2000;
      for (int k = 0; k < 6; k++) begin
         half();
         chk("cont_a_rdy", 32'(a_rdy), 32'(k % 2 == 0));
         chk("cont_b_rdy", 32'(b_rdy), 32'(k % 2 == 1));
         if (k >= 2) begin
            chk("cont_o_vld", 32'(o_vld), 32'd1);
            chk("cont_src", 32'(o_src), 32'(k % 2));
            chk("cont_tag", 32'(o_tag), (k % 2 == 1) ? 32'd2 : 32'd1);
         end
         edge_();
      end
      a_vld = 1'b0; b_vld = 1'b0;
      repeat (3) cyc();

      // back-to-back stream from A
      for (int k = 0; k < 8; k++) begin
         if (k < 6) begin
            a_vld = 1'b1; a_c = bb_c[k]; a_tag = 4'(k);
         end else begin
            a_vld = 1'b0;
         end
         half();
         if (k < 6)
            chk("b2b_a_rdy", 32'(a_rdy), 32'd1);
         if (k >= 2) begin
            chk("b2b_o_vld", 32'(o_vld), 32'd1);
            chk("b2b_cred", 32'(o_cred), 32'(bb_exp[k-2]));
            chk("b2b_tag", 32'(o_tag), 32'(k - 2));
         end
         edge_();
      end
      half();
      chk("b2b_tail_o_vld", 32'(o_vld), 32'd0);
      edge_();

      // backpressure: two in flight, outputs frozen, then drain with refill
      o_rdy = 1'b0; a_vld = 1'b1; idx = 0; acc_stall = 0;
      hold_cred = '0; hold_tag = '0;
      for (int k = 0; k < 8; k++) begin
         if (k == 5) o_rdy = 1'b1;
         a_c = 24'(10 * (idx + 1)); a_tag = 4'(idx);
         half();
         if (k < 2)
            chk("bp_a_rdy_fill", 32'(a_rdy), 32'd1);
         if (k >= 2 && k < 5) begin
            chk("bp_a_rdy_stall", 32'(a_rdy), 32'd0);
            chk("bp_o_vld_stall", 32'(o_vld), 32'd1);
            chk("bp_tag_stall", 32'(o_tag), 32'd0);
            if (k == 2) begin
               hold_cred = o_cred; hold_tag = o_tag;
            end else begin
               chk("bp_cred_hold", 32'(o_cred), 32'(hold_cred));
               chk("bp_tag_hold", 32'(o_tag), 32'(hold_tag));
            end
         end
         if (k == 5) begin
            chk("bp_release_tag", 32'(o_tag), 32'd0);
            chk("bp_release_a_rdy", 32'(a_rdy), 32'd1);
         end
         if (k == 6)
            chk("bp_second_tag", 32'(o_tag), 32'd1);
         if (a_rdy) begin
            idx++;
            if (k < 5) acc_stall++;
         end
         edge_();
      end
      chk("bp_accepted_while_stalled", 32'(acc_stall), 32'd2);
      a_vld = 1'b0;
      repeat (4) cyc();

      // reset with two operands in flight
      o_rdy = 1'b1; a_vld = 1'b1; a_c = 24'd777; a_tag = 4'd7;
      half();
      chk("rstmid_acc0", 32'(a_rdy), 32'd1);
      edge_();
      a_c = 24'd888; a_tag = 4'd8;
      cyc();
      a_c = 24'd999; a_tag = 4'd9; rst = 1'b1;
      half();
      chk("rstmid_a_rdy_in_rst", 32'(a_rdy), 32'd0);
      chk("rstmid_o_vld_before", 32'(o_vld), 32'd1);
      edge_();
      rst = 1'b0; b_vld = 1'b1;
      a_c = 24'd12345; b_c = 24'd54321; a_tag = 4'd3; b_tag = 4'd4;
      half();
      chk("rstmid_o_vld_after", 32'(o_vld), 32'd0);
      chk("rstmid_first_a_rdy", 32'(a_rdy), 32'd1);
      chk("rstmid_first_b_rdy", 32'(b_rdy), 32'd0);
      edge_();
      half();
      chk("rstmid_no_stale", 32'(o_vld), 32'd0);
      chk("rstmid_second_b_rdy", 32'(b_rdy), 32'd1);
      edge_();
      a_vld = 1'b0; b_vld = 1'b0;
      half();
      chk("rstmid_out_a_vld", 32'(o_vld), 32'd1);
      chk("rstmid_out_a_src", 32'(o_src), 32'd0);
      chk("rstmid_out_a_tag", 32'(o_tag), 32'd3);
      edge_();
      half();
      chk("rstmid_out_b_src", 32'(o_src), 32'd1);
      chk("rstmid_out_b_tag", 32'(o_tag), 32'd4);
      edge_();
      half();
      chk("rstmid_tail_o_vld", 32'(o_vld), 32'd0);
      edge_();

      chk("sb_queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
